// File: rtl/piso_shifter_pkg.sv
// Shared types and helpers for the parallel-in/serial-out shift stage.
//   state_t : FSM encoding (IDLE=00, SHIFT=01, DONE=10; 11 is illegal)
//   cnt_w   : width of the bit index for a given word length
package piso_shifter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Bit-index width; never below 1 so the counter always has a real register.
   function automatic int unsigned cnt_w(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_shifter_bit_counter.sv
// Mod-MODULUS up-counter, falling-edge clocked.
//   clk   : clock, updates on negedge
//   clr   : asynchronous active-low clear
//   ce    : active-low enable; 1 freezes the count
//   zero  : synchronous load of 0 (wins over inc)
//   inc   : advance by one, wrapping to 0 after MODULUS-1
//   count : current value
//   tc    : terminal count, high when count == MODULUS-1
module piso_shifter_bit_counter
   import piso_shifter_pkg::*;
#(
   parameter int unsigned MODULUS = 8,
   parameter int unsigned CW      = cnt_w(MODULUS)
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          ce,
   input  logic          zero,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          tc
);

   localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

   assign tc = (count == LAST);

   // Count register
   always_ff @(negedge clk or negedge clr) begin
      if (!clr) begin
         count <= '0;
      end else if (!ce) begin
         if (zero) begin
            count <= '0;
         end else if (inc) begin
            count <= tc ? '0 : count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shift stage, falling-edge clocked, active-low enable.
//   clk    : clock, all state updates on negedge
//   clr    : asynchronous active-low reset
//   ce     : active-low clock enable; 1 freezes all state
//   start  : load request, sampled only in IDLE
//   din    : parallel word, sampled on the load edge
//   sout   : serial data out (0 outside SHIFT)
//   busy   : high while shifting
//   done   : high for the end-of-word state
//   bitcnt : index of the bit currently on sout (0 outside SHIFT)
module piso_shifter
   import piso_shifter_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      ce,
   input  logic                      start,
   input  logic [WIDTH-1:0]          din,
   output logic                      sout,
   output logic                      busy,
   output logic                      done,
   output logic [cnt_w(WIDTH)-1:0]   bitcnt
);

   localparam int unsigned CW = cnt_w(WIDTH);

   state_t          state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    count;
   logic             tc;
   logic             cnt_zero;

   // Counter sits at 0 everywhere except SHIFT; it wraps to 0 on the last bit.
   assign cnt_zero = (state != ST_SHIFT);

   piso_shifter_bit_counter #(
      .MODULUS (WIDTH),
      .CW      (CW)
   ) u_bit_counter (
      .clk   (clk),
      .clr   (clr),
      .ce    (ce),
      .zero  (cnt_zero),
      .inc   (busy),
      .count (count),
      .tc    (tc)
   );

   // FSM and shift register
   always_ff @(negedge clk or negedge clr) begin
      if (!clr) begin
         state <= ST_IDLE;
         sr    <= '0;
      end else if (!ce) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sr    <= din;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (tc) begin
                  sr    <= '0;
                  state <= ST_DONE;
               end else if (MSB_FIRST) begin
                  sr <= {sr[WIDTH-2:0], 1'b0};
               end else begin
                  sr <= {1'b0, sr[WIDTH-1:1]};
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               // Illegal 2'b11 encoding recovers to IDLE
               sr    <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode registered state only
   assign busy   = (state == ST_SHIFT);
   assign done   = (state == ST_DONE);
   assign sout   = busy & (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
   assign bitcnt = busy ? count : '0;

endmodule
